// File: rtl/next_block_gen.sv
// Next-tetromino source: a 7-bag randomiser driven by a free-running 16-bit LFSR.
// Holds one preview piece on buf_block and hands it over on cur_block on request.
module next_block_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       req,
  input  logic       game_over,
  output logic [4:0] buf_block,
  output logic [4:0] cur_block,
  output logic       cur_valid,
  output logic       busy
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]  LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    READY
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [6:0]  bag;
  logic        req_pend;
  logic [3:0]  retry;

  logic [2:0]  idx;
  logic [7:0]  bag_ext;
  logic        rand_ok;
  logic [2:0]  low_idx;
  logic        low_found;
  logic        pick_hit;
  logic [2:0]  pick_idx;
  logic [6:0]  bag_next;

  assign busy = (state != READY);
  assign idx  = lfsr[2:0];

  // Slot 7 is permanently marked taken so idx==7 is simply a miss.
  assign bag_ext = {1'b1, bag};
  assign rand_ok = ~bag_ext[idx];

  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (!bag[i] && !low_found) begin
        low_idx   = 3'(i);
        low_found = 1'b1;
      end
    end
  end

  assign pick_hit = rand_ok || (retry == LAST_TRY);
  assign pick_idx = rand_ok ? idx : low_idx;
  assign bag_next = bag | (7'b0000001 << pick_idx);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      buf_block <= '0;
      cur_block <= '0;
      cur_valid <= 1'b0;
      bag       <= '0;
      req_pend  <= 1'b0;
      retry     <= '0;
      lfsr      <= SEED_EFF;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cur_valid <= 1'b0;
      if (game_over) begin
        state     <= IDLE;
        buf_block <= '0;
        bag       <= '0;
        req_pend  <= 1'b0;
        retry     <= '0;
      end else begin
        case (state)
          IDLE: begin
            buf_block <= '0;
            if (start) begin
              state <= PICK;
              bag   <= '0;
              retry <= '0;
            end
          end
          PICK: begin
            if (req) req_pend <= 1'b1;
            if (pick_hit) begin
              buf_block <= {2'b10, pick_idx};
              bag       <= (bag_next == 7'h7F) ? '0 : bag_next;
              retry     <= '0;
              state     <= READY;
            end else begin
              retry <= retry + 4'd1;
            end
          end
          READY: begin
            if (req || req_pend) begin
              cur_block <= buf_block;
              cur_valid <= 1'b1;
              req_pend  <= 1'b0;
              state     <= PICK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_next_block_gen.sv
// Scoreboard bench for next_block_gen: a reference model queues expected handoffs,
// a negedge monitor compares them and the registered outputs every cycle.
module tb_next_block_gen;

  logic       pclk;
  logic       rst, start, req, game_over;
  logic [4:0] b0_buf, b0_cur, b1_buf, b1_cur;
  logic       b0_valid, b0_busy, b1_valid, b1_busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  next_block_gen dut0 (
    .pclk(pclk), .rst(rst), .start(start), .req(req), .game_over(game_over),
    .buf_block(b0_buf), .cur_block(b0_cur), .cur_valid(b0_valid), .busy(b0_busy)
  );

  next_block_gen #(.MAX_TRIES(1)) dut1 (
    .pclk(pclk), .rst(rst), .start(start), .req(req), .game_over(game_over),
    .buf_block(b1_buf), .cur_block(b1_cur), .cur_valid(b1_valid), .busy(b1_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          st;     // 0 idle, 1 pick, 2 ready
    logic [4:0]  bufb;
    logic [4:0]  cur;
    bit          valid;
    logic [6:0]  bag;
    bit          pend;
    int          retry;
    logic [15:0] l;
  } mdl_t;

  mdl_t m0, m1;
  logic [4:0] q0[$], q1[$];
  logic [4:0] h0[$], h1[$];
  int run = 0, maxrun = 0;

  function automatic mdl_t step(mdl_t m, bit r, bit s, bit q, bit g, int mt);
    mdl_t n;
    int cand, choice;
    n = m;
    if (r) begin
      n.st = 0; n.bufb = 0; n.cur = 0; n.valid = 0;
      n.bag = 0; n.pend = 0; n.retry = 0; n.l = 16'hACE1;
      return n;
    end
    n.l = {m.l[14:0], ^(m.l & 16'hB400)};
    n.valid = 0;
    if (g) begin
      n.st = 0; n.bufb = 0; n.bag = 0; n.pend = 0; n.retry = 0;
      return n;
    end
    case (m.st)
      0: begin
        n.bufb = 0;
        if (s) begin n.st = 1; n.bag = 0; n.retry = 0; end
      end
      1: begin
        if (q) n.pend = 1;
        cand = int'(m.l[2:0]);
        choice = -1;
        if (cand < 7 && !m.bag[cand]) choice = cand;
        else if (m.retry == mt - 1)
          for (int i = 6; i >= 0; i--) if (!m.bag[i]) choice = i;
        if (choice >= 0) begin
          n.bufb = 5'(16 + choice);
          n.bag = m.bag | 7'(1 << choice);
          if (n.bag == 7'h7F) n.bag = 0;
          n.retry = 0;
          n.st = 2;
        end else begin
          n.retry = m.retry + 1;
        end
      end
      default: begin
        if (q || m.pend) begin
          n.cur = m.bufb; n.valid = 1; n.pend = 0; n.st = 1;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge pclk) begin
    m0 = step(m0, rst, start, req, game_over, 8);
    m1 = step(m1, rst, start, req, game_over, 1);
    if (m0.valid) q0.push_back(m0.cur);
    if (m1.valid) q1.push_back(m1.cur);
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (mon_en) begin
      check("m0_buf", 16'(b0_buf), 16'(m0.bufb));
      check("m0_cur", 16'(b0_cur), 16'(m0.cur));
      check("m0_busy", 16'(b0_busy), 16'(m0.st != 2));
      check("m1_buf", 16'(b1_buf), 16'(m1.bufb));
      check("m1_cur", 16'(b1_cur), 16'(m1.cur));
      check("m1_busy", 16'(b1_busy), 16'(m1.st != 2));
      if (b0_valid) begin
        if (q0.size() == 0) check("m0_unexpected_valid", 16'd1, 16'd0);
        else check("m0_handoff", 16'(b0_cur), 16'(q0.pop_front()));
      end else if (q0.size() != 0) begin
        check("m0_missing_valid", 16'd0, 16'd1);
        void'(q0.pop_front());
      end
      if (b1_valid) begin
        if (q1.size() == 0) check("m1_unexpected_valid", 16'd1, 16'd0);
        else check("m1_handoff", 16'(b1_cur), 16'(q1.pop_front()));
      end else if (q1.size() != 0) begin
        check("m1_missing_valid", 16'd0, 16'd1);
        void'(q1.pop_front());
      end
    end
  end

  task automatic cyc;
    @(posedge pclk);
    @(negedge pclk);
    if (b0_valid) h0.push_back(b0_cur);
    if (b1_valid) h1.push_back(b1_cur);
    if (b0_busy) begin
      run++;
      if (run > maxrun) maxrun = run;
    end else run = 0;
  endtask

  task automatic wait_ready0;
    for (int i = 0; i < 20 && b0_busy; i++) cyc();
    if (b0_busy) check("dut0_ready_timeout", 16'(b0_busy), 16'd0);
  endtask

  task automatic wait_ready1;
    for (int i = 0; i < 20 && b1_busy; i++) cyc();
    if (b1_busy) check("dut1_ready_timeout", 16'(b1_busy), 16'd0);
  endtask

  function automatic bit perm7(input logic [4:0] q[$], input int off);
    logic [6:0] seen;
    logic [4:0] v;
    seen = '0;
    if (q.size() < off + 7) return 0;
    for (int i = 0; i < 7; i++) begin
      v = q[off + i];
      if (v < 5'd16 || v > 5'd22) return 0;
      if (seen[v - 5'd16]) return 0;
      seen[v - 5'd16] = 1'b1;
    end
    return seen == 7'h7F;
  endfunction

  task automatic seq6(output logic [4:0] s[6]);
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 6; k++) begin
      repeat (10) cyc();
      req = 1; cyc(); req = 0;
      check("replay_valid", 16'(b0_valid), 16'd1);
      s[k] = b0_cur;
    end
  endtask

  logic [4:0] sa[6], sb[6];
  int n_pulse;

  initial begin
    rst = 1; start = 0; req = 0; game_over = 0;
    @(posedge pclk);
    mon_en = 1;
    @(negedge pclk);
    check("rst_buf", 16'(b0_buf), 16'd0);
    check("rst_cur", 16'(b0_cur), 16'd0);
    check("rst_valid", 16'(b0_valid), 16'd0);
    check("rst_busy", 16'(b0_busy), 16'd1);
    check("rst_busy1", 16'(b1_busy), 16'd1);
    rst = 0;

    // idle ignores req
    req = 1;
    repeat (10) cyc();
    req = 0;
    check("idle_no_handoff", 16'(h0.size() + h1.size()), 16'd0);

    // MAX_TRIES=1: each pick takes exactly one cycle
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 8; k++) begin
      wait_ready1();
      check("mt1_buf_live", 16'(b1_buf[4]), 16'd1);
      req = 1; cyc(); req = 0;
      check("mt1_valid", 16'(b1_valid), 16'd1);
      check("mt1_busy", 16'(b1_busy), 16'd1);
      cyc();
      check("mt1_pick1", 16'(b1_busy), 16'd0);
      check("mt1_strobe1", 16'(b1_valid), 16'd0);
    end
    check("mt1_count", 16'(h1.size()), 16'd8);
    check("mt1_perm", 16'(perm7(h1, 0)), 16'd1);
    check("mt1_eighth", 16'(h1.size() == 8 && h1[7] >= 5'd16 && h1[7] <= 5'd22), 16'd1);

    // default params: two full bags, bounded picking
    game_over = 1; cyc(); game_over = 0;
    h0.delete();
    run = 0; maxrun = 0;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 14; k++) begin
      wait_ready0();
      req = 1; cyc(); req = 0;
    end
    wait_ready0();
    check("bag_count", 16'(h0.size()), 16'd14);
    check("bag1_perm", 16'(perm7(h0, 0)), 16'd1);
    check("bag2_perm", 16'(perm7(h0, 7)), 16'd1);
    check("pick_bound", 16'(maxrun <= 8), 16'd1);

    // several reqs inside one PICK window -> one extra handoff
    h0.delete();
    req = 1; cyc(); req = 0;
    n_pulse = 0;
    while (b0_busy && n_pulse < 3) begin
      req = 1; cyc(); req = 0;
      n_pulse++;
    end
    repeat (30) cyc();
    check("pend_pulses", 16'(n_pulse >= 1), 16'd1);
    check("pend_single", 16'(h0.size()), 16'd2);

    // game_over while picking with a request pending
    wait_ready0();
    req = 1; cyc();
    cyc(); req = 0;
    game_over = 1; cyc(); game_over = 0;
    check("go_buf", 16'(b0_buf), 16'd0);
    check("go_busy", 16'(b0_busy), 16'd1);
    check("go_valid", 16'(b0_valid), 16'd0);
    h0.delete();
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 7; k++) begin
      wait_ready0();
      req = 1; cyc(); req = 0;
    end
    check("go_refill_perm", 16'(perm7(h0, 0)), 16'd1);

    // reset during a handoff strobe, then cycle-exact replay
    rst = 1; cyc(); rst = 0;
    seq6(sa);
    rst = 1; cyc(); rst = 0;
    check("rst2_buf", 16'(b0_buf), 16'd0);
    check("rst2_cur", 16'(b0_cur), 16'd0);
    check("rst2_valid", 16'(b0_valid), 16'd0);
    check("rst2_busy", 16'(b0_busy), 16'd1);
    seq6(sb);
    for (int k = 0; k < 6; k++) check("replay_seq", 16'(sb[k]), 16'(sa[k]));

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
